// File: rtl/fft_pair_buffer.sv
`default_nettype none
// ============================================================================
// fft_pair_buffer : radix-2 DIF input stage, pairs x[n] with x[n+DEPTH]
// Optional sticky frame_err via FFT_FRAME_CHECK_EN.     Rev 1.0
// ============================================================================
module fft_pair_buffer #(
    parameter int DATA_WIDTH    = 17,
    parameter int DEPTH         = 512,
    parameter int TW_ADDR_WIDTH = 9,
    parameter int TW_STRIDE     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [DATA_WIDTH-1:0]    in_re,
    input  logic [DATA_WIDTH-1:0]    in_img,
    output logic                     out_valid,
    output logic                     out_sof,
    output logic [DATA_WIDTH-1:0]    a_re,
    output logic [DATA_WIDTH-1:0]    a_img,
    output logic [DATA_WIDTH-1:0]    b_re,
    output logic [DATA_WIDTH-1:0]    b_img,
    output logic [TW_ADDR_WIDTH-1:0] tw_addr
`ifdef FFT_FRAME_CHECK_EN
    ,
    output logic                     frame_err
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {FILL = 1'b0, PAIR = 1'b1} state_t;

    logic [CW-1:0]            cnt;
    logic [CW-1:0]            cnt_eff;
    logic [AW-1:0]            addr;
    state_t                   state;
    logic [TW_ADDR_WIDTH-1:0] tw_idx;
    logic [2*DATA_WIDTH-1:0]  mem [DEPTH];

    // An accepted sof sample always lands at index 0, whatever the count was.
    assign cnt_eff = in_sof ? '0 : cnt;
    assign addr    = cnt_eff[AW-1:0];
    assign state   = state_t'(cnt_eff[CW-1]);
    assign tw_idx  = TW_ADDR_WIDTH'(32'(addr) * 32'(TW_STRIDE));

    always_ff @(posedge clk) begin
        if (in_valid && state == FILL)
            mem[addr] <= {in_re, in_img};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            a_re      <= '0;
            a_img     <= '0;
            b_re      <= '0;
            b_img     <= '0;
            tw_addr   <= '0;
        end else begin
            out_valid <= in_valid && (state == PAIR);
            out_sof   <= in_valid && (state == PAIR) && (addr == '0);
            if (in_valid)
                cnt <= cnt_eff + CW'(1);
            // Read and write never collide: reads only happen in PAIR.
            if (in_valid && state == PAIR) begin
                {a_re, a_img} <= mem[addr];
                b_re          <= in_re;
                b_img         <= in_img;
                tw_addr       <= tw_idx;
            end
        end
    end

`ifdef FFT_FRAME_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_err <= 1'b0;
        else if (in_valid && in_sof && cnt != '0)
            frame_err <= 1'b1;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_pair_buffer.sv
`default_nettype none
// ============================================================================
// tb_fft_pair_buffer : directed self-checking bench, DEPTH=4      Rev 1.0
// ============================================================================
module tb_fft_pair_buffer;

    localparam int DW = 17;
    localparam int D  = 4;
    localparam int TW = 2;
    localparam int PW = 1 + 4*DW + TW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_sof;
    logic [DW-1:0] in_re, in_img;
    logic          out_valid, out_sof, out_valid2, out_sof2;
    logic [DW-1:0] a_re, a_img, b_re, b_img;
    logic [DW-1:0] a_re2, a_img2, b_re2, b_img2;
    logic [TW-1:0] tw_addr, tw_addr2;
`ifdef FFT_FRAME_CHECK_EN
    logic          frame_err, frame_err2;
`endif

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    fft_pair_buffer #(.DATA_WIDTH(DW), .DEPTH(D), .TW_ADDR_WIDTH(TW), .TW_STRIDE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_re(in_re), .in_img(in_img), .out_valid(out_valid), .out_sof(out_sof),
        .a_re(a_re), .a_img(a_img), .b_re(b_re), .b_img(b_img), .tw_addr(tw_addr)
`ifdef FFT_FRAME_CHECK_EN
        , .frame_err(frame_err)
`endif
    );

    fft_pair_buffer #(.DATA_WIDTH(DW), .DEPTH(D), .TW_ADDR_WIDTH(TW), .TW_STRIDE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_re(in_re), .in_img(in_img), .out_valid(out_valid2), .out_sof(out_sof2),
        .a_re(a_re2), .a_img(a_img2), .b_re(b_re2), .b_img(b_img2), .tw_addr(tw_addr2)
`ifdef FFT_FRAME_CHECK_EN
        , .frame_err(frame_err2)
`endif
    );

    function automatic logic [DW-1:0] re_of(input int n);
        return DW'(n);
    endfunction

    function automatic logic [DW-1:0] im_of(input int n);
        return DW'(-n);
    endfunction

    // Apply one input cycle, then land 1 time unit past the capturing edge.
    task automatic drive(input logic v, input logic s, input logic [DW-1:0] re, input logic [DW-1:0] im);
        in_valid = v;
        in_sof   = s;
        in_re    = re;
        in_img   = im;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [PW+1:0] got;
        rst_n = 1'b0;
        in_valid = 1'b0; in_sof = 1'b0; in_re = '0; in_img = '0;
        repeat (2) @(posedge clk);
        #1;
        got = {out_valid, out_sof, a_re, a_img, b_re, b_img, tw_addr, out_valid2, tw_addr2 != '0};
        total++;
        if (got !== '0) $display("FAIL reset_outputs got=%h want=0", got);
        else pass_cnt++;
`ifdef FFT_FRAME_CHECK_EN
        total++;
        if (frame_err !== 1'b0) $display("FAIL reset_frame_err got=%b want=0", frame_err);
        else pass_cnt++;
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_continuous;
        logic [PW-1:0] got, exp;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, re_of(i), im_of(i));
            total++;
            if (out_valid !== (i >= 4)) $display("FAIL cont_valid[%0d] got=%b want=%b", i, out_valid, i >= 4);
            else pass_cnt++;
            if (i >= 4) begin
                got = {out_sof, a_re, a_img, b_re, b_img, tw_addr};
                exp = {i == 4, re_of(i-4), im_of(i-4), re_of(i), im_of(i), TW'(i-4)};
                total++;
                if (got !== exp) $display("FAIL cont_pair[%0d] got=%h want=%h", i, got, exp);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_gaps;
        logic [PW-1:0] got, exp;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, re_of(i), im_of(i));
            if (i >= 4) begin
                got = {out_sof, a_re, a_img, b_re, b_img, tw_addr};
                exp = {i == 4, re_of(i-4), im_of(i-4), re_of(i), im_of(i), TW'(i-4)};
                total++;
                if (out_valid !== 1'b1 || got !== exp)
                    $display("FAIL gap_pair[%0d] got=%b/%h want=1/%h", i, out_valid, got, exp);
                else pass_cnt++;
            end
            drive(1'b0, 1'b0, 17'h1ABCD, 17'h05555);
            total++;
            if (out_valid !== 1'b0) $display("FAIL gap_idle_valid[%0d] got=%b want=0", i, out_valid);
            else pass_cnt++;
            if (i >= 4) begin
                got = {out_sof, a_re, a_img, b_re, b_img, tw_addr};
                exp = {1'b0, re_of(i-4), im_of(i-4), re_of(i), im_of(i), TW'(i-4)};
                total++;
                if (got !== exp) $display("FAIL gap_hold[%0d] got=%h want=%h", i, got, exp);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [PW-1:0] got, exp;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i == 0, re_of(i), im_of(i));
            total++;
            if (out_valid !== ((i % 8) >= 4)) $display("FAIL b2b_valid[%0d] got=%b want=%b", i, out_valid, (i % 8) >= 4);
            else pass_cnt++;
            if ((i % 8) >= 4) begin
                got = {out_sof, a_re, a_img, b_re, b_img, tw_addr};
                exp = {(i % 8) == 4, re_of(i-4), im_of(i-4), re_of(i), im_of(i), TW'((i % 8) - 4)};
                total++;
                if (got !== exp) $display("FAIL b2b_pair[%0d] got=%h want=%h", i, got, exp);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_stride;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, re_of(i+40), im_of(i+40));
            if (i >= 4) begin
                total++;
                if (out_valid2 !== 1'b1 || tw_addr2 !== TW'((i-4)*2))
                    $display("FAIL stride_tw[%0d] got=%b/%0d want=1/%0d", i, out_valid2, tw_addr2, ((i-4)*2) % 4);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [PW:0]   got;
        logic [PW-1:0] pg, exp;
        for (int i = 0; i < 6; i++) drive(1'b1, i == 0, re_of(i+60), im_of(i+60));
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sof = 1'b0;
        #1;
        got = {out_valid, out_sof, a_re, a_img, b_re, b_img, tw_addr};
        total++;
        if (got !== '0) $display("FAIL rstmid_async got=%h want=0", got);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        got = {out_valid, out_sof, a_re, a_img, b_re, b_img, tw_addr};
        total++;
        if (got !== '0 || tw_addr2 !== '0) $display("FAIL rstmid_held got=%h/%h want=0/0", got, tw_addr2);
        else pass_cnt++;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, re_of(i), im_of(i));
            pg  = {out_sof, a_re, a_img, b_re, b_img, tw_addr};
            exp = {i == 4, re_of(i-4), im_of(i-4), re_of(i), im_of(i), TW'(i-4)};
            total++;
            if (out_valid !== (i >= 4) || (i >= 4 && pg !== exp))
                $display("FAIL rstmid_pair[%0d] got=%b/%h want=%b/%h", i, out_valid, pg, i >= 4, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_extremes;
        logic [DW-1:0] vr [8];
        logic [DW-1:0] vi [8];
        logic [PW-1:0] got, exp;
        for (int i = 0; i < 8; i++) begin
            vr[i] = re_of(i+7);
            vi[i] = im_of(i+7);
        end
        vr[0] = 17'h0FFFF; vi[0] = 17'h10000;
        vr[4] = 17'h10000; vi[4] = 17'h0FFFF;
        vr[1] = 17'h1FFFF; vi[5] = 17'h00000;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, vr[i], vi[i]);
            if (i >= 4) begin
                got = {out_sof, a_re, a_img, b_re, b_img, tw_addr};
                exp = {i == 4, vr[i-4], vi[i-4], vr[i], vi[i], TW'(i-4)};
                total++;
                if (out_valid !== 1'b1 || got !== exp)
                    $display("FAIL extreme_pair[%0d] got=%b/%h want=1/%h", i, out_valid, got, exp);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_resync;
        logic [PW-1:0] got, exp;
        drive(1'b1, 1'b1, re_of(100), im_of(100));
        drive(1'b1, 1'b0, re_of(101), im_of(101));
`ifdef FFT_FRAME_CHECK_EN
        total++;
        if (frame_err !== 1'b0) $display("FAIL resync_err_before got=%b want=0", frame_err);
        else pass_cnt++;
`endif
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, re_of(i+200), im_of(i+200));
`ifdef FFT_FRAME_CHECK_EN
            total++;
            if (frame_err !== 1'b1) $display("FAIL resync_err[%0d] got=%b want=1", i, frame_err);
            else pass_cnt++;
`endif
            got = {out_sof, a_re, a_img, b_re, b_img, tw_addr};
            exp = {i == 4, re_of(i+196), im_of(i+196), re_of(i+200), im_of(i+200), TW'(i-4)};
            total++;
            if (out_valid !== (i >= 4) || (i >= 4 && got !== exp))
                $display("FAIL resync_pair[%0d] got=%b/%h want=%b/%h", i, out_valid, got, i >= 4, exp);
            else pass_cnt++;
        end
        drive(1'b0, 1'b0, '0, '0);
`ifdef FFT_FRAME_CHECK_EN
        total++;
        if (frame_err !== 1'b1) $display("FAIL resync_err_sticky got=%b want=1", frame_err);
        else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gaps();
        test_back_to_back();
        test_stride();
        test_reset_mid();
        test_extremes();
        test_resync();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total);
        $fatal(1);
    end

endmodule
`default_nettype wire
